iter_muldiv: RTL and testbench
==============================

// Module: iter_muldiv
// PURPOSE
//  Iterative signed 32-bit multiply/divide unit feeding the register-file write port.
//  Accepts one operation at a time, computes it in WIDTH iterations, then emits a
//  one-cycle result_rdy pulse with the result, destination tag and exception flag.
//  result_rdy and wb_tag drive the register file's write-enable and write-select logic.
// PARAMETERS
//  WIDTH   32  operand/result width; iteration count per mult/div
//  TAG_W   5   destination register tag width (32 architectural registers)
// PORTS
//  clk         in   1        rising-edge clock; the only clock
//  clr         in   1        synchronous, active-high reset
//  start_mult  in   1        request signed multiply, sampled on a rising edge in IDLE/DONE
//  start_div   in   1        request signed divide, sampled on a rising edge in IDLE/DONE
//  operand_a   in   WIDTH    multiplicand / dividend, captured on accept
//  operand_b   in   WIDTH    multiplier / divisor, captured on accept
//  dest_tag    in   TAG_W    destination register, captured on accept
//  busy        out  1        high in BUSY state
//  result_rdy  out  1        one-cycle pulse: result valid for write-back
//  result      out  WIDTH    low WIDTH bits of product, or truncated quotient
//  exception   out  1        overflow or divide-by-zero; valid with result_rdy
//  wb_tag      out  TAG_W    dest_tag of the completed operation
// BEHAVIOUR
//  - Reset: on a clk edge with clr=1 -> state IDLE; busy, result_rdy, exception = 0;
//    result = 0; wb_tag = 0. clr overrides all other inputs, including mid-operation
//    (the operation is aborted and produces no result_rdy).
//  - States: IDLE, BUSY, DONE.
//    IDLE: exactly one of start_mult/start_div = 1 -> capture operands, tag and op; go to BUSY
//      with counter = 0. Both high or both low -> remain IDLE (no capture).
//    BUSY: one iteration per cycle; counter increments; after WIDTH iterations -> DONE.
//      Start inputs are ignored in BUSY; captured operands are not affected by input changes.
//    DONE: result_rdy = 1 for this single cycle. A valid start in DONE is accepted exactly as
//      in IDLE (next state BUSY); otherwise the next state is IDLE.
//  - Latency: accept at edge N -> result_rdy high during the cycle after edge N+WIDTH+1
//    (WIDTH=32: 33 edges). Back-to-back issue, with a start asserted while in DONE, gives one
//    result every WIDTH+1 cycles.
//  - Multiply: signed two's complement, full 2*WIDTH product formed internally.
//    result = product[WIDTH-1:0].
//    exception = 1 iff the product is not representable in WIDTH signed bits.
//  - Divide: signed; quotient truncated toward zero; remainder discarded.
//    divisor = 0: skip BUSY (IDLE/DONE -> DONE on the next edge); result = 0; exception = 1.
//    Dividend = 0x80000000 and divisor = -1: result = 0x80000000; exception = 1.
//  - result, exception and wb_tag update only on entry to DONE. They hold their values until
//    the next DONE or reset. exception is meaningful only while result_rdy = 1.
//  - Write-back consumer writes result to wb_tag when result_rdy & ~exception.
// TESTING
//  1 mult 7 x -6, tag 3 -> 33 edges after accept: result_rdy=1 for 1 cycle,
//    result=0xFFFFFFD6, exception=0, wb_tag=3.
//  2 mult 0x00010000 x 0x00010000 -> result=0x00000000, exception=1.
//  3 div -7 / 2 -> result=0xFFFFFFFD (-3), exception=0.
//    div 0x80000000 / -1 -> result=0x80000000, exception=1.
//  4 div 5 / 0, tag 9 -> result_rdy one edge after accept; result=0, exception=1, wb_tag=9.
//  5 start pulsed during BUSY with new operands -> ignored; the original result is unchanged.
//    start asserted in DONE -> next result exactly 33 cycles later.
//    start_mult & start_div both high in IDLE -> busy stays 0.
//  6 clr=1 at iteration 10 of a mult -> next cycle busy=0, result=0, no result_rdy pulse;
//    a new mult 3 x 4 after clr=0 -> result=12.

Source files
------------

// File: rtl/iter_muldiv.sv
// ============================================================================
// Module   : iter_muldiv
// Purpose  : Iterative signed multiply/divide unit for register-file write-back.
//            One operation at a time. A multiply or divide runs WIDTH iterations
//            plus one sign-fix/overflow cycle. The unit then pulses result_rdy
//            for one cycle with the result, the destination tag and an
//            exception flag.
// Ports    : clk, clr (synchronous, active-high)
//            start_mult / start_div  - request; accepted in IDLE or DONE
//            operand_a / operand_b   - multiplicand/dividend, multiplier/divisor
//            dest_tag                - destination register tag
//            busy                    - operation in progress
//            result_rdy              - one-cycle write-back strobe
//            result, exception       - low WIDTH product bits / truncated
//                                      quotient, and overflow or divide-by-zero
//            wb_tag                  - tag of the completed operation
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_muldiv #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] dest_tag,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [TAG_W-1:0] wb_tag
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Both operations work on magnitudes. r_acc is the product high half
    // (multiply) or the partial remainder (divide). r_lo is the multiplier
    // shifting out and the product low half shifting in (multiply), or the
    // dividend shifting out and the quotient shifting in (divide). r_opd is
    // the multiplicand or divisor magnitude.
    logic             r_is_div;
    logic             r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opd;
    logic [TAG_W-1:0] r_tag;

    logic             w_start_ok;
    logic             w_div0;
    logic             w_finish;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_rem_ge;
    logic [WIDTH-1:0] w_rem_sub;
    logic [WIDTH-1:0] w_signed_lo;
    logic             w_fin_exc;

    // ------------------------------------------------------------------------
    // Request qualification and operand magnitudes
    // ------------------------------------------------------------------------
    always_comb begin
        w_start_ok = (r_state != S_BUSY) && (start_mult ^ start_div);
        w_div0     = start_div && (operand_b == '0);
        w_finish   = (r_state == S_BUSY) && (r_cnt == CNT_W'(WIDTH));
        w_a_mag    = operand_a[WIDTH-1] ? -operand_a : operand_a;
        w_b_mag    = operand_b[WIDTH-1] ? -operand_b : operand_b;
    end

    // ------------------------------------------------------------------------
    // Per-iteration datapath
    // ------------------------------------------------------------------------
    always_comb begin
        // Shift-add multiply step: conditionally add, then shift {sum, lo} right.
        w_mul_sum = {1'b0, r_acc};
        if (r_lo[0]) begin
            w_mul_sum = {1'b0, r_acc} + {1'b0, r_opd};
        end
        // Restoring divide step. The remainder stays below the divisor
        // (<= 2**(WIDTH-1)), so a WIDTH-bit subtract is exact when taken.
        w_rem_sh  = {r_acc, r_lo[WIDTH-1]};
        w_rem_ge  = (w_rem_sh >= {1'b0, r_opd});
        w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opd;
    end

    // ------------------------------------------------------------------------
    // Final sign fix and overflow detection
    // ------------------------------------------------------------------------
    always_comb begin
        // The low WIDTH bits of a negated 2*WIDTH product equal the negation
        // of the low WIDTH bits, so one negator serves both operations.
        w_signed_lo = r_neg ? -r_lo : r_lo;
        if (r_is_div) begin
            // Only -2**(WIDTH-1) / -1 yields a positive quotient of 2**(WIDTH-1).
            w_fin_exc = !r_neg && r_lo[WIDTH-1];
        end else if (r_neg) begin
            // A negative product may reach a magnitude of exactly 2**(WIDTH-1).
            w_fin_exc = (|r_acc) || (r_lo[WIDTH-1] && (|r_lo[WIDTH-2:0]));
        end else begin
            w_fin_exc = (|r_acc) || r_lo[WIDTH-1];
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        result_rdy  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                result_rdy = (r_state == S_DONE);
                if (w_start_ok) begin
                    // Divide-by-zero needs no iterations.
                    w_state_nxt = w_div0 ? S_DONE : S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (w_finish) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_is_div  <= 1'b0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_lo      <= '0;
            r_opd     <= '0;
            r_tag     <= '0;
            result    <= '0;
            exception <= 1'b0;
            wb_tag    <= '0;
        end else if (w_start_ok) begin
            r_is_div <= start_div;
            r_neg    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            r_cnt    <= '0;
            r_acc    <= '0;
            r_tag    <= dest_tag;
            if (start_div) begin
                r_lo  <= w_a_mag;
                r_opd <= w_b_mag;
            end else begin
                r_lo  <= w_b_mag;
                r_opd <= w_a_mag;
            end
            if (w_div0) begin
                result    <= '0;
                exception <= 1'b1;
                wb_tag    <= dest_tag;
            end
        end else if (r_state == S_BUSY) begin
            if (w_finish) begin
                result    <= w_signed_lo;
                exception <= w_fin_exc;
                wb_tag    <= r_tag;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (r_is_div) begin
                    r_acc <= w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
                    r_lo  <= {r_lo[WIDTH-2:0], w_rem_ge};
                end else begin
                    r_acc <= w_mul_sum[WIDTH:1];
                    r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iter_muldiv.sv
// ============================================================================
// Module   : tb_iter_muldiv
// Purpose  : Self-checking bench for iter_muldiv. It runs directed and random
//            multiply/divide operations against an arithmetic reference model
//            and checks latency, result, exception and tag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_muldiv;

    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          clr;
    logic          start_mult;
    logic          start_div;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [TW-1:0] dest_tag;
    logic          busy;
    logic          result_rdy;
    logic [W-1:0]  result;
    logic          exception;
    logic [TW-1:0] wb_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iter_muldiv #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .clr        (clr),
        .start_mult (start_mult),
        .start_div  (start_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .dest_tag   (dest_tag),
        .busy       (busy),
        .result_rdy (result_rdy),
        .result     (result),
        .exception  (exception),
        .wb_tag     (wb_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision signed arithmetic.
    function automatic void model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic e);
        int     sa;
        int     sb;
        longint p;
        int     q;
        sa = a;
        sb = b;
        if (!is_div) begin
            p = longint'(sa) * longint'(sb);
            r = p[31:0];
            e = (p > longint'(32'sh7FFFFFFF)) || (p < longint'(32'sh80000000));
        end else if (sb == 0) begin
            r = '0;
            e = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            r = 32'h80000000;
            e = 1'b1;
        end else begin
            q = sa / sb;
            r = q;
            e = 1'b0;
        end
    endfunction

    // Called at #1 after a rising edge. Drives the request so that the next
    // edge samples it, then counts edges until result_rdy appears.
    task automatic run_op(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input bit disturb, input bit check_tail);
        logic [W-1:0] er;
        logic         ee;
        int           lat;
        int           exp_lat;
        model(is_div, a, b, er, ee);
        exp_lat    = (is_div && b == '0) ? 0 : 33;
        start_mult = !is_div;
        start_div  = is_div;
        operand_a  = a;
        operand_b  = b;
        dest_tag   = tag;
        @(posedge clk); #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        operand_a  = $urandom;
        operand_b  = $urandom;
        dest_tag   = TW'($urandom);
        lat = 0;
        if (exp_lat > 0) check("busy_after_accept", 64'(busy), 64'd1);
        while (!result_rdy && lat < 40) begin
            if (disturb && lat == 5) begin
                start_mult = 1'b1;
                operand_a  = $urandom;
                operand_b  = $urandom;
                dest_tag   = TW'($urandom);
            end
            if (disturb && lat == 6) start_mult = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", 64'(result), 64'(er));
        check("exception", 64'(exception), 64'(ee));
        check("wb_tag", 64'(wb_tag), 64'(tag));
        if (check_tail) begin
            @(posedge clk); #1;
            check("rdy_single_cycle", 64'(result_rdy), 64'd0);
            check("result_hold", 64'(result), 64'(er));
        end
    endtask

    initial begin
        int          seen;
        int          kind;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        clr        = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        operand_a  = '0;
        operand_b  = '0;
        dest_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdy", 64'(result_rdy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_exc", 64'(exception), 64'd0);
        check("rst_tag", 64'(wb_tag), 64'd0);
        clr = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(1'b0, 32'd7, 32'hFFFFFFFA, 5'd3, 1'b0, 1'b1);
        run_op(1'b0, 32'h00010000, 32'h00010000, 5'd4, 1'b0, 1'b1);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 5'd5, 1'b0, 1'b1);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd6, 1'b0, 1'b1);
        run_op(1'b1, 32'd5, 32'd0, 5'd9, 1'b0, 1'b1);
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd7, 1'b0, 1'b1);
        run_op(1'b0, 32'h80000000, 32'd1, 5'd8, 1'b0, 1'b1);
        run_op(1'b1, 32'h80000000, 32'd1, 5'd10, 1'b0, 1'b1);

        // Start during BUSY is ignored
        run_op(1'b0, 32'd12345, 32'hFFFF0001, 5'd11, 1'b1, 1'b1);

        // Back-to-back issue from DONE
        run_op(1'b0, 32'd100, 32'd200, 5'd12, 1'b0, 1'b0);
        run_op(1'b1, 32'd1000, 32'hFFFFFFF9, 5'd13, 1'b0, 1'b0);
        run_op(1'b1, 32'd77, 32'd0, 5'd14, 1'b0, 1'b0);
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 1'b0, 1'b1);

        // Both starts high: no accept
        start_mult = 1'b1;
        start_div  = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (busy || result_rdy) seen++;
        end
        start_mult = 1'b0;
        start_div  = 1'b0;
        check("both_starts_ignored", 64'(seen), 64'd0);

        // clr in the middle of a multiply aborts it
        start_mult = 1'b1;
        operand_a  = 32'h01234567;
        operand_b  = 32'h00000089;
        dest_tag   = 5'd21;
        @(posedge clk); #1;
        start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_result", 64'(result), 64'd0);
        check("clr_rdy", 64'(result_rdy), 64'd0);
        check("clr_tag", 64'(wb_tag), 64'd0);
        clr  = 1'b0;
        seen = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk); #1;
            if (result_rdy) seen++;
        end
        check("no_rdy_after_clr", 64'(seen), 64'd0);
        run_op(1'b0, 32'd3, 32'd4, 5'd2, 1'b0, 1'b1);

        // Random operations
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            ra   = $urandom;
            rb   = $urandom;
            case (kind)
                0: run_op(1'b0, ra, rb, TW'($urandom), 1'b0, 1'($urandom));
                1: begin
                    ra = {{16{ra[15]}}, ra[15:0]};
                    rb = {{17{rb[14]}}, rb[14:0]};
                    run_op(1'b0, ra, rb, TW'($urandom), 1'b0, 1'($urandom));
                end
                2: run_op(1'b1, ra, rb, TW'($urandom), 1'b0, 1'($urandom));
                3: begin
                    rb = {{24{rb[7]}}, rb[7:0]};
                    if (rb == '0) rb = 32'd3;
                    run_op(1'b1, ra, rb, TW'($urandom), 1'b0, 1'($urandom));
                end
                4: run_op(1'b1, ra, 32'd0, TW'($urandom), 1'b0, 1'($urandom));
                default: run_op(1'($urandom), 32'h80000000, 32'hFFFFFFFF, TW'($urandom), 1'b0, 1'b1);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
